// File: rtl/muldiv_pkg.sv
// Shared constants and types for the MULTU/DIVU iterative unit.
package muldiv_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;

   typedef enum logic {
      OP_MULTU = 1'b0,
      OP_DIVU  = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   // Iteration counter width: enough to hold WIDTH-1 with one spare bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic             op,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] hi_nxt_c,
   output logic [WIDTH-1:0] lo_nxt_c
);

   logic [WIDTH:0]   sum_c;
   logic [WIDTH:0]   shifted_c;
   logic [WIDTH-1:0] sub_c;

   // MULTU: add multiplicand when multiplier LSB set, shift {hi,lo} right.
   // DIVU: shift next dividend bit into remainder, subtract divisor if it fits.
   always_comb begin
      hi_nxt_c  = acc_hi;
      lo_nxt_c  = acc_lo;
      sum_c     = '0;
      shifted_c = '0;
      sub_c     = '0;
      if (op == OP_MULTU) begin
         sum_c    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
         hi_nxt_c = sum_c[WIDTH:1];
         lo_nxt_c = {sum_c[0], acc_lo[WIDTH-1:1]};
      end else begin
         shifted_c = {acc_hi, acc_lo[WIDTH-1]};
         // Result is below the divisor whenever it is used, so WIDTH bits suffice.
         sub_c     = shifted_c[WIDTH-1:0] - operand;
         if (shifted_c >= {1'b0, operand}) begin
            hi_nxt_c = sub_c;
            lo_nxt_c = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt_c = shifted_c[WIDTH-1:0];
            lo_nxt_c = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULTU/DIVU controller: FSM, iteration counter, accumulators, HI/LO.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mf_req,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] acc_hi, acc_hi_nxt;
   logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
   logic [WIDTH-1:0] opnd, opnd_nxt;
   logic             op_r, op_r_nxt;
   logic             dz_pend, dz_pend_nxt;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
   logic             div_zero_nxt;
   logic [WIDTH-1:0] step_hi_c, step_lo_c;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op       (op_r),
      .acc_hi   (acc_hi),
      .acc_lo   (acc_lo),
      .operand  (opnd),
      .hi_nxt_c (step_hi_c),
      .lo_nxt_c (step_lo_c)
   );

   // Next-state and datapath update; HI/LO only written when leaving FIN.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      acc_hi_nxt   = acc_hi;
      acc_lo_nxt   = acc_lo;
      opnd_nxt     = opnd;
      op_r_nxt     = op_r;
      dz_pend_nxt  = dz_pend;
      hi_nxt       = hi;
      lo_nxt       = lo;
      div_zero_nxt = div_zero;
      case (state)
         ST_IDLE: begin
            if (start && !flush) begin
               cnt_nxt     = '0;
               op_r_nxt    = op;
               dz_pend_nxt = 1'b0;
               if (op == OP_MULTU) begin
                  acc_hi_nxt = '0;
                  acc_lo_nxt = rt_val;
                  opnd_nxt   = rs_val;
                  state_nxt  = ST_MUL;
               end else if (rt_val != '0) begin
                  acc_hi_nxt   = '0;
                  acc_lo_nxt   = rs_val;
                  opnd_nxt     = rt_val;
                  div_zero_nxt = 1'b0;
                  state_nxt    = ST_DIV;
               end else begin
                  acc_hi_nxt  = rs_val;
                  acc_lo_nxt  = '1;
                  dz_pend_nxt = 1'b1;
                  state_nxt   = ST_FIN;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (flush) begin
               cnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end else begin
               acc_hi_nxt = step_hi_c;
               acc_lo_nxt = step_lo_c;
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_FIN;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         ST_FIN: begin
            state_nxt = ST_IDLE;
            if (!flush) begin
               hi_nxt = acc_hi;
               lo_nxt = acc_lo;
               if (dz_pend) begin
                  div_zero_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         op_r     <= 1'b0;
         dz_pend  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         acc_hi   <= acc_hi_nxt;
         acc_lo   <= acc_lo_nxt;
         opnd     <= opnd_nxt;
         op_r     <= op_r_nxt;
         dz_pend  <= dz_pend_nxt;
         hi       <= hi_nxt;
         lo       <= lo_nxt;
         div_zero <= div_zero_nxt;
      end
   end

   // Status decode; a flush during FIN suppresses the completion pulse.
   always_comb begin
      busy  = (state != ST_IDLE);
      done  = (state == ST_FIN) && !flush;
      stall = busy && (mf_req || start);
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl.
module tb_muldiv_ctrl;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, op, mf_req, flush;
   logic [W-1:0] rs_val, rt_val;
   logic         busy, stall, done, div_zero;
   logic [W-1:0] hi, lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   exp_t         sb[$];
   int           checks   = 0;
   int           failures = 0;
   logic         model_dz = 1'b0;
   logic [W-1:0] last_hi  = '0;
   logic [W-1:0] last_lo  = '0;

   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .mf_req   (mf_req),
      .flush    (flush),
      .busy     (busy),
      .stall    (stall),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one start strobe; optionally record the reference result.
   task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push);
      exp_t e;
      if (o == 1'b0) begin
         {e.hi, e.lo} = 64'(a) * 64'(b);
         e.dz = model_dz;
      end else if (b == '0) begin
         e.hi = a;
         e.lo = '1;
         e.dz = 1'b1;
      end else begin
         e.hi = a % b;
         e.lo = a / b;
         e.dz = 1'b0;
      end
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      if (push) begin
         sb.push_back(e);
         model_dz = e.dz;
      end
   endtask

   // Wait (bounded) for done, check latency and stall, then compare with the scoreboard.
   task automatic wait_done(input int exp_lat, input bit scramble, input bit mf);
      int   cyc  = 0;
      bit   seen = 1'b0;
      exp_t e;
      while (cyc < 100 && !seen) begin
         @(negedge clk);
         cyc++;
         start  = 1'b0;
         mf_req = mf;
         if (scramble) begin
            rs_val = $urandom;
            rt_val = $urandom;
         end
         #1;
         if (done) seen = 1'b1;
         if (mf) check("stall_busy", 64'(stall), 64'(1));
         if (cyc == 5 && !seen) begin
            check("hi_mid_op", 64'(hi), 64'(last_hi));
            check("lo_mid_op", 64'(lo), 64'(last_lo));
         end
      end
      check("done_seen", 64'(seen), 64'(1));
      check("latency", 64'(cyc), 64'(exp_lat));
      @(negedge clk);
      #1;
      check("busy_after", 64'(busy), 64'(0));
      if (mf) check("stall_idle", 64'(stall), 64'(0));
      mf_req = 1'b0;
      if (sb.size() == 0) begin
         check("sb_nonempty", 64'(0), 64'(1));
      end else begin
         e = sb.pop_front();
         check("hi", 64'(hi), 64'(e.hi));
         check("lo", 64'(lo), 64'(e.lo));
         check("div_zero", 64'(div_zero), 64'(e.dz));
         last_hi = e.hi;
         last_lo = e.lo;
      end
   endtask

   initial begin
      logic         ro;
      logic [W-1:0] ra, rb;
      rst_n  = 1'b0;
      start  = 1'b0;
      op     = 1'b0;
      mf_req = 1'b0;
      flush  = 1'b0;
      rs_val = '0;
      rt_val = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
      check("rst_dz", 64'(div_zero), 64'(0));
      rst_n = 1'b1;

      // Directed cases: full-scale product, plain divide, divide by zero, flag clear.
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_done(33, 1'b0, 1'b0);
      issue(1'b1, 32'd100, 32'd7, 1'b1);
      wait_done(33, 1'b0, 1'b0);
      issue(1'b1, 32'd7, 32'd0, 1'b1);
      wait_done(1, 1'b0, 1'b0);
      issue(1'b1, 32'd100, 32'd7, 1'b1);
      wait_done(33, 1'b0, 1'b0);

      // MULTU with move-from request pending behind it.
      issue(1'b0, 32'd3, 32'd5, 1'b1);
      wait_done(33, 1'b0, 1'b1);

      // Flush a DIVU at cycle 10.
      issue(1'b1, 32'd1000, 32'd3, 1'b0);
      repeat (9) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_no_done", 64'(done), 64'(0));
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_idle", 64'(busy), 64'(0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("flush_quiet", 64'(done), 64'(0));
      end
      check("flush_hi", 64'(hi), 64'(last_hi));
      check("flush_lo", 64'(lo), 64'(last_lo));

      // Flush and start together in IDLE: start is dropped.
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      check("flush_start_idle", 64'(busy), 64'(0));

      // Reset at cycle 16 of a MULTU.
      issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      repeat (15) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", 64'(busy), 64'(0));
      check("mrst_done", 64'(done), 64'(0));
      check("mrst_hi", 64'(hi), 64'(0));
      check("mrst_lo", 64'(lo), 64'(0));
      @(negedge clk);
      rst_n    = 1'b1;
      model_dz = 1'b0;
      last_hi  = '0;
      last_lo  = '0;
      issue(1'b0, 32'd12345, 32'd6789, 1'b1);
      wait_done(33, 1'b0, 1'b0);

      // Random operations with operand inputs scrambled after acceptance.
      for (int i = 0; i < 8; i++) begin
         ro = 1'($urandom_range(1, 0));
         ra = $urandom;
         rb = (i == 3) ? '0 : $urandom;
         if (i == 5) rb = 32'd1;
         issue(ro, ra, rb, 1'b1);
         wait_done((ro && rb == '0) ? 1 : 33, 1'b1, 1'b0);
      end

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
